// File: rtl/mem_stage_ctrl_if.sv
// Data-memory handshake bundle between the MEM-stage controller (master)
// and a variable-latency data memory (slave).
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller feeding the MEM/WB register; stalls upstream
// while a data-memory access is outstanding. Optional abort: MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        wb_i,
  input  logic [1:0]        m_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        rd_i,
  mem_stage_ctrl_if.master  mem,
  output logic              stall_o,
  output logic [1:0]        wb_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [4:0]        rd_o,
  output logic              err_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_mem_op;
  logic              w_ack;
  logic              w_timeout;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_wb;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_alu;
  logic [4:0]        r_rd;

  assign w_mem_op = |m_i;
  assign w_ack    = (r_state == ACCESS) && mem.mem_ack_i;

`ifdef MEM_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err;

  // Abort fires on the cycle whose increment would reach TIMEOUT_CYC; an ack
  // in that same cycle takes priority and completes normally.
  assign w_timeout = (r_state == ACCESS) && !mem.mem_ack_i && (r_wait_cnt == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == IDLE)
        r_wait_cnt <= '0;
      else if (!mem.mem_ack_i)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  // NOTE: state register in its own always_ff; all next-state decoding lives in always_comb.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          stall_o     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (mem.mem_ack_i || w_timeout) w_state_nxt = IDLE;
        else                            stall_o     = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb        <= '0;
      r_rdata     <= '0;
      r_alu       <= '0;
      r_rd        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= m_i[0];
            r_mem_addr  <= addr_i;
            r_mem_wdata <= wdata_i;
            r_wb        <= '0;
          end else begin
            r_wb    <= wb_i;
            r_alu   <= addr_i;
            r_rd    <= rd_i;
            r_rdata <= '0;
          end
        end
        ACCESS: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_wb      <= wb_i;
            r_alu     <= addr_i;
            r_rd      <= rd_i;
            r_rdata   <= r_mem_we ? '0 : mem.mem_rdata_i;
          end else if (w_timeout) begin
            // Aborted access retires as a non-writing instruction.
            r_mem_req <= 1'b0;
            r_wb      <= '0;
            r_alu     <= addr_i;
            r_rd      <= rd_i;
            r_rdata   <= '0;
          end else begin
            r_wb <= '0;
          end
        end
        default: r_mem_req <= 1'b0;
      endcase
    end
  end

  assign mem.mem_req_o   = r_mem_req;
  assign mem.mem_we_o    = r_mem_we;
  assign mem.mem_addr_o  = r_mem_addr;
  assign mem.mem_wdata_o = r_mem_wdata;
  assign wb_o            = r_wb;
  assign rdata_o         = r_rdata;
  assign alu_o           = r_alu;
  assign rd_o            = r_rd;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized
// instruction streams against a per-instruction behavioural model.
module tb_mem_stage_ctrl;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        wb_i;
  logic [1:0]        m_i;
  logic [DATA_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [4:0]        rd_i;
  logic              stall_o;
  logic [1:0]        wb_o;
  logic [DATA_W-1:0] rdata_o;
  logic [DATA_W-1:0] alu_o;
  logic [4:0]        rd_o;
  logic              err_o;

  int total = 0;
  int bad   = 0;

  mem_stage_ctrl_if #(.DATA_W(DATA_W)) mem_bus ();

  mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wb_i    (wb_i),
    .m_i     (m_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rd_i    (rd_i),
    .mem     (mem_bus.master),
    .stall_o (stall_o),
    .wb_o    (wb_o),
    .rdata_o (rdata_o),
    .alu_o   (alu_o),
    .rd_o    (rd_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  // One instruction through the MEM stage. Entered and left at posedge+1 with
  // the controller idle. lat = ACCESS cycles without ack before the ack cycle.
  task automatic do_instr(input logic [1:0] wb, input logic [1:0] m,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int lat,
                          input logic [31:0] ld_data, input string tag);
    logic [31:0] exp_rdata;
    logic [70:0] exp_retire;
    int          stalls;
    wb_i = wb; m_i = m; addr_i = addr; wdata_i = wdata; rd_i = rd;
    mem_bus.mem_ack_i = 1'b0;
    total++;
    if (mem_bus.mem_req_o !== 1'b0) begin
      bad++; $display("FAIL %s req_gap: got %b want 0", tag, mem_bus.mem_req_o);
    end
    exp_rdata  = (m == 2'b10) ? ld_data : 32'h0;
    exp_retire = {wb, addr, rd, exp_rdata};
    @(negedge clk_i);
    total++;
    if (stall_o !== (m != 2'b00)) begin
      bad++; $display("FAIL %s detect_stall: got %b want %b", tag, stall_o, (m != 2'b00));
    end
    stalls = (m != 2'b00) ? 1 : 0;
    if (m != 2'b00) begin
      for (int k = 0; k <= lat; k++) begin
        @(posedge clk_i); #1;
        total++;
        if ({mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o, wb_o}
            !== {1'b1, m[0], addr, wdata, 2'b00}) begin
          bad++;
          $display("FAIL %s access_bus k=%0d: got req=%b we=%b addr=%h wdata=%h wb=%b want req=1 we=%b addr=%h wdata=%h wb=00",
                   tag, k, mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o,
                   mem_bus.mem_wdata_o, wb_o, m[0], addr, wdata);
        end
        mem_bus.mem_ack_i   = (k == lat);
        mem_bus.mem_rdata_i = (k == lat) ? ld_data : $urandom;
        @(negedge clk_i);
        if (stall_o === 1'b1) stalls++;
      end
    end
    @(posedge clk_i); #1;
    mem_bus.mem_ack_i = 1'b0;
    total++;
    if (stalls != ((m != 2'b00) ? lat + 1 : 0)) begin
      bad++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, (m != 2'b00) ? lat + 1 : 0);
    end
    total++;
    if ({wb_o, alu_o, rd_o, rdata_o} !== exp_retire) begin
      bad++;
      $display("FAIL %s retire: got wb=%b alu=%h rd=%0d rdata=%h want wb=%b alu=%h rd=%0d rdata=%h",
               tag, wb_o, alu_o, rd_o, rdata_o, wb, addr, rd, exp_rdata);
    end
    total++;
    if (mem_bus.mem_req_o !== 1'b0) begin
      bad++; $display("FAIL %s req_drop: got %b want 0", tag, mem_bus.mem_req_o);
    end
    m_i = 2'b00;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; wb_i = 2'b11; m_i = 2'b00; addr_i = 32'hFFFF_FFFF;
    wdata_i = 32'hFFFF_FFFF; rd_i = 5'd31;
    mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = '0;
    #12;
    total++;
    if ({mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o,
         wb_o, rdata_o, alu_o, rd_o, err_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h wb=%b rdata=%h alu=%h rd=%0d err=%b want all 0",
               mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o,
               wb_o, rdata_o, alu_o, rd_o, err_o);
    end
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_passthru();
    do_instr(2'b10, 2'b00, 32'h1234, 32'h0, 5'd5, 0, 32'h0, "passthru");
  endtask

  task automatic test_load();
    do_instr(2'b11, 2'b10, 32'h40, 32'h0, 5'd9, 3, 32'hDEAD_BEEF, "load");
  endtask

  task automatic test_store();
    do_instr(2'b00, 2'b01, 32'h80, 32'hCAFE_F00D, 5'd0, 0, 32'h0, "store");
    do_instr(2'b01, 2'b11, 32'h84, 32'h1357_9BDF, 5'd3, 1, 32'hFFFF_0000, "store_m11");
  endtask

  task automatic test_back_to_back();
    do_instr(2'b11, 2'b10, 32'h100, 32'h0, 5'd1, 1, 32'h1111_2222, "b2b_load0");
    do_instr(2'b11, 2'b10, 32'h104, 32'h0, 5'd2, 0, 32'h3333_4444, "b2b_load1");
  endtask

  task automatic test_reset_mid_access();
    wb_i = 2'b11; m_i = 2'b10; addr_i = 32'h200; wdata_i = 32'h0; rd_i = 5'd4;
    mem_bus.mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    total++;
    if (mem_bus.mem_req_o !== 1'b1) begin
      bad++; $display("FAIL rst_mid pre_req: got %b want 1", mem_bus.mem_req_o);
    end
    #2 rst_i = 1'b0;
    #1;
    total++;
    if ({mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, wb_o, rdata_o, alu_o, rd_o} !== '0) begin
      bad++;
      $display("FAIL rst_mid async_clear: got req=%b addr=%h wb=%b alu=%h want 0",
               mem_bus.mem_req_o, mem_bus.mem_addr_o, wb_o, alu_o);
    end
    m_i = 2'b00; wb_i = 2'b00; addr_i = '0; rd_i = '0;
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid late_ack_stall: got %b want 0", stall_o);
    end
    @(posedge clk_i); #1;
    mem_bus.mem_ack_i = 1'b0;
    total++;
    if ({mem_bus.mem_req_o, wb_o, rdata_o, alu_o, rd_o} !== '0) begin
      bad++;
      $display("FAIL rst_mid late_ack_ignored: got req=%b wb=%b rdata=%h want all 0",
               mem_bus.mem_req_o, wb_o, rdata_o);
    end
    do_instr(2'b01, 2'b10, 32'h204, 32'h0, 5'd6, 2, 32'h0BAD_F00D, "rst_mid_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_instr(2'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom,
               5'($urandom), $urandom_range(0, TIMEOUT_CYC - 1), $urandom, "random");
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL timeout pre_err: got %b want 0", err_o);
    end
    wb_i = 2'b11; m_i = 2'b10; addr_i = 32'h300; wdata_i = 32'h0; rd_i = 5'd7;
    mem_bus.mem_ack_i = 1'b0;
    @(negedge clk_i);
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      @(posedge clk_i); #1;
      total++;
      if ({mem_bus.mem_req_o, wb_o} !== {1'b1, 2'b00}) begin
        bad++; $display("FAIL timeout wait k=%0d: got req=%b wb=%b want req=1 wb=00", k, mem_bus.mem_req_o, wb_o);
      end
      @(negedge clk_i);
      total++;
      if (stall_o !== (k < TIMEOUT_CYC)) begin
        bad++; $display("FAIL timeout stall k=%0d: got %b want %b", k, stall_o, (k < TIMEOUT_CYC));
      end
    end
    @(posedge clk_i); #1;
    m_i = 2'b00;
    total++;
    if ({mem_bus.mem_req_o, err_o, wb_o, rdata_o} !== {1'b0, 1'b1, 2'b00, 32'h0}) begin
      bad++;
      $display("FAIL timeout abort: got req=%b err=%b wb=%b rdata=%h want req=0 err=1 wb=00 rdata=0",
               mem_bus.mem_req_o, err_o, wb_o, rdata_o);
    end
    do_instr(2'b10, 2'b10, 32'h304, 32'h0, 5'd8, 1, 32'h7777_8888, "timeout_next");
    total++;
    if (err_o !== 1'b1) begin
      bad++; $display("FAIL timeout err_sticky: got %b want 1", err_o);
    end
  endtask
`else
  task automatic test_no_timeout();
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL err_const: got %b want 0", err_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_passthru();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
